// File: rtl/branch_tracker_pkg.sv
// Shared types and defaults for the branch resolve tracker: one queue entry
// holds the fetched branch PC and the direction the predictor returned for it.
package branch_tracker_pkg;

    localparam int BT_DEPTH = 4;
    localparam int BT_PC_W  = 32;

    typedef struct packed {
        logic [BT_PC_W-1:0] pc;
        logic               taken;
    } br_entry_t;

endpackage

// File: rtl/branch_tracker_queue.sv
// In-order circular buffer of predicted branches; push/pop take effect at the edge,
// clear wins over both. Head entry and count are visible the cycle after any change.
module branch_tracker_queue
    import branch_tracker_pkg::*;
#(
    parameter int DEPTH = BT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  br_entry_t                push_dat_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output br_entry_t                head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    br_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/branch_resolve_tracker.sv
// Tracks in-flight predicted branches and trains the predictor as they resolve (1-cycle latency);
// pred_rdy drops when full, resolve_rdy drops when empty, and a mispredict flushes younger entries.
module branch_resolve_tracker
    import branch_tracker_pkg::*;
#(
    parameter int DEPTH = BT_DEPTH,
    parameter int PC_W  = BT_PC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pred_val,
    output logic                   pred_rdy,
    input  logic [PC_W-1:0]        pred_pc,
    input  logic                   pred_taken,
    input  logic                   resolve_val,
    output logic                   resolve_rdy,
    input  logic                   resolve_taken,
    output logic                   update_en,
    output logic                   update_val,
    output logic [PC_W-1:0]        update_pc,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] num_inflight,
    output logic [31:0]            num_branches,
    output logic [31:0]            num_mispred
);

    localparam int CW = $clog2(DEPTH) + 1;

    br_entry_t         head_ent;
    br_entry_t         push_ent;
    logic [CW-1:0]     count;
    logic              enq_fire, res_fire, mis_fire;

    logic              update_en_q, update_val_q, mispredict_q;
    logic [PC_W-1:0]   update_pc_q;
    logic [31:0]       num_branches_q, num_mispred_q;

    assign pred_rdy    = (count != CW'(DEPTH));
    assign resolve_rdy = (count != '0);
    assign enq_fire    = pred_val && pred_rdy;
    assign res_fire    = resolve_val && resolve_rdy;
    assign mis_fire    = res_fire && (head_ent.taken != resolve_taken);

    assign push_ent.pc    = pred_pc;
    assign push_ent.taken = pred_taken;

    // A push alongside a mispredict is wrong-path work and is dropped by the flush.
    branch_tracker_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (enq_fire && !mis_fire),
        .push_dat_i (push_ent),
        .pop_i      (res_fire),
        .clear_i    (mis_fire),
        .head_dat_o (head_ent),
        .count_o    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            update_en_q    <= 1'b0;
            update_val_q   <= 1'b0;
            update_pc_q    <= '0;
            mispredict_q   <= 1'b0;
            num_branches_q <= '0;
            num_mispred_q  <= '0;
        end else begin
            update_en_q  <= res_fire;
            mispredict_q <= mis_fire;
            if (res_fire) begin
                update_val_q   <= resolve_taken;
                update_pc_q    <= head_ent.pc;
                num_branches_q <= num_branches_q + 32'd1;
            end
            if (mis_fire) num_mispred_q <= num_mispred_q + 32'd1;
        end
    end

    assign update_en    = update_en_q;
    assign update_val   = update_val_q;
    assign update_pc    = update_pc_q;
    assign mispredict   = mispredict_q;
    assign num_inflight = count;
    assign num_branches = num_branches_q;
    assign num_mispred  = num_mispred_q;

endmodule
